// File: rtl/uart_in_source_if.sv
// Handshake bundle between the stimulus side and the UART input character source.
// The master drives pushes and read requests; the slave (the source) answers.
interface uart_in_source_if;
    logic       push_valid;
    logic       push_ready;
    logic [7:0] push_ch;
    logic       flush;
    logic       uart_in_valid;
    logic [7:0] uart_in_ch;

    modport master (
        output push_valid, push_ch, flush, uart_in_valid,
        input  push_ready, uart_in_ch
    );

    modport slave (
        input  push_valid, push_ch, flush, uart_in_valid,
        output push_ready, uart_in_ch
    );
endinterface

// File: rtl/uart_in_source.sv
// Simulation-side UART input source: buffers pushed characters in a circular FIFO and
// answers each SimTop read request combinationally with the next character or 8'hff.
module uart_in_source #(
    parameter int DEPTH    = 16,
    parameter int CHAR_GAP = 0,
    parameter int CNT_W    = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    uart_in_source_if.slave        bus,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       delivered_cnt,
    output logic [CNT_W-1:0]       empty_read_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = (CHAR_GAP > 0) ? $clog2(CHAR_GAP + 1) : 1;

    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_rp;
    logic [AW-1:0]    r_wp;
    logic [LW-1:0]    r_level;
    logic [GW-1:0]    r_gap_cnt;
    logic [CNT_W-1:0] r_delivered_cnt;
    logic [CNT_W-1:0] r_empty_read_cnt;

    logic             w_push_ready;
    logic             w_avail;
    logic             w_push;
    logic             w_pop;
    logic             w_empty_read;
    logic [LW-1:0]    w_level_nxt;
    logic [GW-1:0]    w_gap_nxt;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        w_push_ready = (r_level < LW'(DEPTH)) && !bus.flush && reset;
        w_avail      = reset && (r_level != '0) && (r_gap_cnt == '0);
        w_push       = bus.push_valid && w_push_ready;
        w_pop        = bus.uart_in_valid && w_avail;
        w_empty_read = reset && bus.uart_in_valid && !w_avail;

        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase

        // A pop restarts pacing; otherwise the gap drains one per cycle regardless of requests.
        w_gap_nxt = r_gap_cnt;
        if (w_pop) begin
            w_gap_nxt = GW'(CHAR_GAP);
        end else if (r_gap_cnt != '0) begin
            w_gap_nxt = r_gap_cnt - 1'b1;
        end
    end

    // NOTE: the character store has no reset; pointers and level alone define what is valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wp] <= bus.push_ch;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rp             <= '0;
            r_wp             <= '0;
            r_level          <= '0;
            r_gap_cnt        <= '0;
            r_delivered_cnt  <= '0;
            r_empty_read_cnt <= '0;
        end else begin
            if (bus.flush) begin
                r_rp      <= '0;
                r_wp      <= '0;
                r_level   <= '0;
                r_gap_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_wp <= r_wp + 1'b1;
                end
                if (w_pop) begin
                    r_rp <= r_rp + 1'b1;
                end
                r_level   <= w_level_nxt;
                r_gap_cnt <= w_gap_nxt;
            end

            // Statistics survive a flush; a pop in the flush cycle is still counted.
            if (w_pop) begin
                r_delivered_cnt <= r_delivered_cnt + 1'b1;
            end
            if (w_empty_read && (r_empty_read_cnt != '1)) begin
                r_empty_read_cnt <= r_empty_read_cnt + 1'b1;
            end
        end
    end

    assign bus.push_ready  = w_push_ready;
    assign bus.uart_in_ch  = w_avail ? r_mem[r_rp] : 8'hff;
    assign fifo_level      = r_level;
    assign delivered_cnt   = r_delivered_cnt;
    assign empty_read_cnt  = r_empty_read_cnt;

endmodule

// File: tb/tb_uart_in_source.sv
// Scoreboard bench for uart_in_source: two instances (small depth / no gap, and paced)
// share one stimulus stream and are each compared against a queue-based reference model.
module tb_uart_in_source;
    localparam int NI = 2;
    localparam int DEPTH_A = 4, GAP_A = 0, CW_A = 4;
    localparam int DEPTH_B = 8, GAP_B = 3, CW_B = 32;

    typedef logic [7:0] ch_q_t [$];

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic       push_valid = 1'b0;
    logic [7:0] push_ch = 8'h00;
    logic       flush = 1'b0;
    logic       uart_in_valid = 1'b0;

    always #5 clk = ~clk;

    uart_in_source_if if_a ();
    uart_in_source_if if_b ();

    assign if_a.push_valid    = push_valid;
    assign if_a.push_ch       = push_ch;
    assign if_a.flush         = flush;
    assign if_a.uart_in_valid = uart_in_valid;
    assign if_b.push_valid    = push_valid;
    assign if_b.push_ch       = push_ch;
    assign if_b.flush         = flush;
    assign if_b.uart_in_valid = uart_in_valid;

    logic [$clog2(DEPTH_A):0] lvl_a;
    logic [$clog2(DEPTH_B):0] lvl_b;
    logic [CW_A-1:0] dcnt_a, ecnt_a;
    logic [CW_B-1:0] dcnt_b, ecnt_b;

    uart_in_source #(.DEPTH(DEPTH_A), .CHAR_GAP(GAP_A), .CNT_W(CW_A)) u_dut_a (
        .clock(clk), .reset(reset), .bus(if_a),
        .fifo_level(lvl_a), .delivered_cnt(dcnt_a), .empty_read_cnt(ecnt_a)
    );

    uart_in_source #(.DEPTH(DEPTH_B), .CHAR_GAP(GAP_B), .CNT_W(CW_B)) u_dut_b (
        .clock(clk), .reset(reset), .bus(if_b),
        .fifo_level(lvl_b), .delivered_cnt(dcnt_b), .empty_read_cnt(ecnt_b)
    );

    // Reference model: characters held in a queue, pacing as "earliest cycle of next delivery".
    int     m_depth [NI] = '{DEPTH_A, DEPTH_B};
    int     m_gap   [NI] = '{GAP_A, GAP_B};
    longint m_max   [NI] = '{(64'd1 << CW_A) - 1, (64'd1 << CW_B) - 1};
    ch_q_t  mq      [NI];
    ch_q_t  exp_q   [NI];
    longint next_ok [NI];
    longint m_dcnt  [NI];
    longint m_ecnt  [NI];
    longint cyc = 0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint dut_level(int k);
        return (k == 0) ? longint'(lvl_a) : longint'(lvl_b);
    endfunction
    function automatic longint dut_dcnt(int k);
        return (k == 0) ? longint'(dcnt_a) : longint'(dcnt_b);
    endfunction
    function automatic longint dut_ecnt(int k);
        return (k == 0) ? longint'(ecnt_a) : longint'(ecnt_b);
    endfunction
    function automatic longint dut_ready(int k);
        return (k == 0) ? longint'(if_a.push_ready) : longint'(if_b.push_ready);
    endfunction
    function automatic longint dut_ch(int k);
        return (k == 0) ? longint'(if_a.uart_in_ch) : longint'(if_b.uart_in_ch);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NI; k++) begin
            mq[k].delete();
            next_ok[k] = 0;
            m_dcnt[k]  = 0;
            m_ecnt[k]  = 0;
        end
    endtask

    task automatic check_state();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("level%0d", k), dut_level(k), longint'(mq[k].size()));
            check($sformatf("delivered%0d", k), dut_dcnt(k), m_dcnt[k]);
            check($sformatf("empty_reads%0d", k), dut_ecnt(k), m_ecnt[k]);
        end
    endtask

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic cycle(input logic pv, input logic [7:0] ch, input logic fl, input logic rv);
        logic   rdy;
        logic   avail;
        push_valid    = pv;
        push_ch       = ch;
        flush         = fl;
        uart_in_valid = rv;
        #1;
        check_state();
        for (int k = 0; k < NI; k++) begin
            rdy   = reset && (mq[k].size() < m_depth[k]) && !fl;
            avail = reset && (mq[k].size() != 0) && (cyc >= next_ok[k]);
            check($sformatf("push_ready%0d", k), dut_ready(k), longint'(rdy));
            if (rv) exp_q[k].push_back(avail ? mq[k][0] : 8'hff);
            if (reset) begin
                if (rv && avail) begin
                    void'(mq[k].pop_front());
                    m_dcnt[k]  = (m_dcnt[k] + 1) & m_max[k];
                    next_ok[k] = cyc + m_gap[k] + 1;
                end else if (rv && (m_ecnt[k] < m_max[k])) begin
                    m_ecnt[k]++;
                end
                if (pv && rdy) mq[k].push_back(ch);
                if (fl) begin
                    mq[k].delete();
                    next_ok[k] = cyc + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic rv);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, rv);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        idle(3, 1'b1);
        reset = 1'b1;
        idle(1, 1'b0);
    endtask

    // Monitor: every request cycle, compare the response against the oldest expectation.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (uart_in_valid) begin
                for (int k = 0; k < NI; k++) begin
                    if (exp_q[k].size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL resp%0d: got %0h, no expectation queued", k, dut_ch(k));
                    end else begin
                        e = exp_q[k].pop_front();
                        check($sformatf("resp%0d", k), dut_ch(k), longint'(e));
                    end
                end
            end
        end
    end

    initial begin
        model_clear();
        @(posedge clk);
        #1;

        // Reset state: requests while held in reset answer ff and are not counted.
        idle(3, 1'b1);
        check("rst_ready_a", longint'(if_a.push_ready), 0);
        check("rst_ch_a", longint'(if_a.uart_in_ch), 64'hff);
        reset = 1'b1;
        #1;
        check("rel_ready_a", longint'(if_a.push_ready), 1);
        check("rel_level_a", longint'(lvl_a), 0);
        idle(1, 1'b0);

        // Ordering and latency.
        cycle(1'b1, 8'h41, 1'b0, 1'b0);
        cycle(1'b1, 8'h42, 1'b0, 1'b0);
        cycle(1'b1, 8'h43, 1'b0, 1'b0);
        idle(4, 1'b1);
        check("t2_delivered_a", longint'(dcnt_a), 3);
        check("t2_empty_a", longint'(ecnt_a), 1);
        check("t2_delivered_b", longint'(dcnt_b), 1);

        // Full boundary and pointer wrap.
        do_reset();
        for (int i = 1; i <= 6; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        check("t3_full_level_a", longint'(lvl_a), 4);
        check("t3_full_ready_a", longint'(if_a.push_ready), 0);
        cycle(1'b1, 8'h07, 1'b0, 1'b1);
        idle(1, 1'b1);
        cycle(1'b1, 8'h05, 1'b0, 1'b0);
        cycle(1'b1, 8'h06, 1'b0, 1'b0);
        idle(4, 1'b1);
        check("t3_delivered_a", longint'(dcnt_a), 6);
        check("t3_empty_a", longint'(ecnt_a), 0);

        // Pacing: the gapped instance shows three ff answers between its two characters.
        do_reset();
        cycle(1'b1, 8'h61, 1'b0, 1'b0);
        cycle(1'b1, 8'h62, 1'b0, 1'b0);
        idle(5, 1'b1);
        check("t4_delivered_b", longint'(dcnt_b), 2);
        check("t4_empty_b", longint'(ecnt_b), 3);

        // Flush drops the buffer and the concurrent push, keeps the counters.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h7a, 1'b1, 1'b0);
        check("t5_level_a", longint'(lvl_a), 0);
        check("t5_level_b", longint'(lvl_b), 0);
        idle(1, 1'b1);
        check("t5_delivered_a", longint'(dcnt_a), 0);
        check("t5_empty_a", longint'(ecnt_a), 1);

        // Saturation of the narrow empty-read counter.
        do_reset();
        idle(20, 1'b1);
        check("t6_empty_sat_a", longint'(ecnt_a), 15);
        check("t6_empty_b", longint'(ecnt_b), 20);

        // Randomized traffic, including mid-operation resets and flushes.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) begin
                reset = 1'b0;
                model_clear();
                cycle(1'($urandom), 8'($urandom), 1'b0, 1'($urandom));
                reset = 1'b1;
            end
            cycle(1'($urandom_range(99) < 55), 8'($urandom),
                  1'($urandom_range(59) == 0), 1'($urandom_range(99) < 50));
        end

        idle(2, 1'b0);
        for (int k = 0; k < NI; k++) check($sformatf("leftover%0d", k), longint'(exp_q[k].size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
